me_integer: RTL

//  Integer-pel refinement stage of the motion estimator. On a 4-phase req/ack handshake from control_top, takes a
//  6+6-bit start position and exhaustively evaluates a 4x4 grid of candidates at offsets dy,dx in {0..3}.

---
 rtl/me_integer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/me_integer.sv
// Integer-pel SAD search over a 4x4 candidate grid from a start position.
// Optional ME_INT_EARLY_TERM_EN: abandon a candidate once its partial SAD reaches the best.
module me_integer #(
  parameter int BLK   = 16,
  parameter int PIX_W = 8,
  parameter int SAD_W = 16,
  parameter int SW_AW = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [11:0]            init_pos,
  output logic                   ack,
  output logic [SAD_W-1:0]       min_sad,
  output logic [3:0]             min_diff,
  output logic                   rd_en,
  output logic [2*$clog2(BLK)-1:0] tpl_addr,
  input  logic [PIX_W-1:0]       tpl_rdata,
  output logic [SW_AW-1:0]       sw_row,
  output logic [SW_AW-1:0]       sw_col,
  input  logic [PIX_W-1:0]       sw_rdata
);

  localparam int LB = $clog2(BLK);
  localparam int PW = 2 * LB;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CMP,
    WAIT_FALL
  } state_t;

  state_t state, state_nxt;

  logic [5:0]       y0;
  logic [5:0]       x0;
  logic [3:0]       cand;
  logic [PW-1:0]    pix;
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] best;
  logic [3:0]       best_diff;
  logic             pv;

  logic [PIX_W-1:0] adiff;
  logic [SAD_W-1:0] acc_sum;
  logic             better;
  logic             last_pix;
  logic             last_cand;
  logic             abort;

  assign adiff = (tpl_rdata > sw_rdata) ? (tpl_rdata - sw_rdata)
                                        : (sw_rdata - tpl_rdata);
  assign acc_sum = acc + {{(SAD_W-PIX_W){1'b0}}, adiff};
  assign better = acc < best;
  assign last_pix = (pix == {PW{1'b1}});
  assign last_cand = (cand == 4'hF);

  assign ack = (state == WAIT_FALL);
  assign tpl_addr = pix;
  assign sw_row = SW_AW'(y0) + SW_AW'(cand[3:2])
                + SW_AW'(pix[PW-1:LB]);
  assign sw_col = SW_AW'(x0) + SW_AW'(cand[1:0])
                + SW_AW'(pix[LB-1:0]);

  always_comb begin
    state_nxt = state;
    abort = 1'b0;
`ifdef ME_INT_EARLY_TERM_EN
    // Candidate 0 always runs to completion so best becomes a real SAD.
    abort = (state == RUN) && (cand != 4'd0) && (acc >= best);
`else
    abort = 1'b0;
`endif
    rd_en = (state == RUN) && !abort;
    unique case (state)
      IDLE:      if (req) state_nxt = RUN;
      RUN: begin
        if (abort) state_nxt = CMP;
        else if (last_pix) state_nxt = DRAIN;
      end
      DRAIN:     state_nxt = CMP;
      CMP:       state_nxt = last_cand ? WAIT_FALL : RUN;
      WAIT_FALL: if (!req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0        <= '0;
      x0        <= '0;
      cand      <= '0;
      pix       <= '0;
      acc       <= '0;
      best      <= '0;
      best_diff <= '0;
      pv        <= 1'b0;
      min_sad   <= '0;
      min_diff  <= '0;
    end else begin
      // pv marks that the memories return data for last cycle's address.
      pv <= rd_en;
      unique case (state)
        IDLE: begin
          if (req) begin
            y0   <= init_pos[11:6];
            x0   <= init_pos[5:0];
            cand <= '0;
            pix  <= '0;
            acc  <= '0;
            best <= '1;
          end
        end
        RUN: begin
          if (abort) begin
            pix <= '0;
          end else begin
            pix <= pix + 1'b1;
            if (pv) acc <= acc_sum;
          end
        end
        DRAIN: begin
          if (pv) acc <= acc_sum;
        end
        CMP: begin
          acc <= '0;
          pix <= '0;
          if (better) begin
            best      <= acc;
            best_diff <= cand;
          end
          if (last_cand) begin
            min_sad  <= better ? acc : best;
            min_diff <= better ? cand : best_diff;
          end else begin
            cand <= cand + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
